md5_digest_check: RTL and testbench
===================================

# md5_digest_check

Final stage of the MD5 brute-force datapath, directly downstream of the last of the 64 chained `hash_op` stages. It adds the MD5 initial values to the round-64 a/b/c/d words and byte-orders the result into the canonical 128-bit digest. It then compares the digest against a target hash, counts hashed candidates and latches the sequence index of the first match for the host-side controller. It stalls in lock-step with the hash pipeline through the shared `en`.

## Interface

Parameters:
- `IDX_W`, 32, width of the candidate counter and match index.

Ports:
- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `en` in 1: pipeline advance; same signal that drives the `hash_op` chain; when low every register in this block holds.
- `in_valid` in 1: the a/b/c/d presented this cycle belong to a real candidate; sampled only when `en`=1.
- `a_in`, `b_in`, `c_in`, `d_in` in 32 each: round-64 outputs of the last `hash_op`.
- `target_hash` in 128: digest to search for, canonical byte order (byte 0 in [127:120]); held stable by the controller while searching.
- `match_clear` in 1: single-cycle pulse; clears `match` and `match_multi`; acts regardless of `en`.
- `digest` out 128: canonical digest of the most recent stage-2 entry.
- `digest_valid` out 1: `digest` holds a real candidate.
- `match` out 1: sticky; a digest equal to `target_hash` has been seen.
- `match_multi` out 1: sticky; a further match arrived while `match` was already set.
- `match_index` out IDX_W: sequence index of the first matching candidate.
- `hash_count` out IDX_W: number of valid candidates accepted at the input.

## Operation

- Initial values: IV_A=0x67452301, IV_B=0xefcdab89, IV_C=0x98badcfe, IV_D=0x10325476. Adds are mod 2^32; carries are discarded.
- Index tagging: on `en && in_valid`, the candidate takes tag = `hash_count`, and `hash_count` increments, wrapping 2^IDX_W-1 -> 0. The tag travels with its data through both stages.
- Stage 1 (on `en`):
  - s1_A=a_in+IV_A, s1_B=b_in+IV_B, s1_C=c_in+IV_C, s1_D=d_in+IV_D.
  - s1_valid=in_valid; s1_tag=tag.
- Canonical form: each word is byte-swapped (bswap), then concatenated as {bswap(A), bswap(B), bswap(C), bswap(D)}. Low byte of A becomes [127:120].
- Stage 2 (on `en`):
  - `digest` <= canonical form of s1.
  - `digest_valid` <= s1_valid.
  - hit = s1_valid && (canonical form of s1 == `target_hash`), a full 128-bit compare.
- Match latch, evaluated on a cycle with `en` and hit:
  - If `match` is 0, or `match_clear` is asserted in the same cycle: `match`<=1, `match_index`<=s1_tag, `match_multi`<=0. A new hit beats a simultaneous clear.
  - Otherwise `match_multi`<=1 and `match_index` is unchanged.
- `match_clear` without a hit: `match`<=0, `match_multi`<=0; `match_index` keeps its last value.
- Invalid entries (`in_valid`=0) flow through the stages, never hit and never count.

## Timing

- Reset values: `digest`=0, `digest_valid`=0, `match`=0, `match_multi`=0, `match_index`=0, `hash_count`=0. Internal s1_* registers are also zeroed.
- Reset mid-operation: in-flight candidates are discarded, and the counter restarts at 0 on the next accepted candidate.
- Latency is two `en`-qualified edges: a candidate accepted at edge N appears on `digest`/`digest_valid`, with `match` and `match_index` if it hits, after edge N+1.
  - `en` low cycles stretch this latency without loss or duplication.
- `hash_count` updates on the same edge the candidate is accepted.
- Throughput is one candidate per `en` cycle; there is no backpressure.
- `match_clear` while `en`=0 takes effect on that edge; the pipeline holds.
- `target_hash` is sampled combinationally at stage 2 entry. Changing it mid-run applies to entries leaving stage 1 from that edge on.

## Test plan

- Reset, then 5 cycles of `en`=1, `in_valid`=0 -> all outputs 0; `hash_count`=0.
- Empty-string vector: `a_in`=0x7246fad3, `b_in`=0x14e45506, `c_in`=0xff4ea3eb, `d_in`=0x6e10a476; `target_hash`=0xd41d8cd98f00b204e9800998ecf8427e; sent as the 4th valid candidate -> two edges later `digest` equals the target, `digest_valid`=1, `match`=1, `match_index`=3; `hash_count`=4.
- All-zero inputs, valid, target 0 -> `digest`=0x0123456789abcdeffedcba9876543210 and no match.
- Stall: drop `en` for 3 cycles between acceptance and output -> outputs frozen during the stall; the digest appears after the 2nd `en` edge.
- Two matching candidates at indices 7 and 9 -> `match_index`=7, `match_multi`=1. Then pulse `match_clear` on the same edge as a new hit at index 12 -> `match`=1, `match_index`=12, `match_multi`=0.
- Counter wrap with IDX_W=4: 17 valid candidates -> `hash_count`=1; the 17th candidate, if matching, gives `match_index`=0.

Source files
------------

// File: rtl/md5_digest_check.sv
// Final MD5 stage: adds the IVs, byte-orders the digest, compares it to the target and latches the first match.
// Ports: clk, reset, en, in_valid, a_in..d_in, target_hash, match_clear -> digest, digest_valid, match, match_multi, match_index, hash_count.
module md5_digest_check #(
  parameter int IDX_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             in_valid,
  input  logic [31:0]      a_in,
  input  logic [31:0]      b_in,
  input  logic [31:0]      c_in,
  input  logic [31:0]      d_in,
  input  logic [127:0]     target_hash,
  input  logic             match_clear,
  output logic [127:0]     digest,
  output logic             digest_valid,
  output logic             match,
  output logic             match_multi,
  output logic [IDX_W-1:0] match_index,
  output logic [IDX_W-1:0] hash_count
);

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  logic [31:0]      s1_a;
  logic [31:0]      s1_b;
  logic [31:0]      s1_c;
  logic [31:0]      s1_d;
  logic             s1_valid;
  logic [IDX_W-1:0] s1_tag;
  logic [127:0]     canon;
  logic             hit;

  assign canon = {bswap(s1_a), bswap(s1_b),
                  bswap(s1_c), bswap(s1_d)};

  assign hit = en && s1_valid &&
               (canon == target_hash);

  // Stage 1/2 datapath and candidate counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_a         <= '0;
      s1_b         <= '0;
      s1_c         <= '0;
      s1_d         <= '0;
      s1_valid     <= 1'b0;
      s1_tag       <= '0;
      digest       <= '0;
      digest_valid <= 1'b0;
      hash_count   <= '0;
    end else if (en) begin
      s1_a         <= a_in + IV_A;
      s1_b         <= b_in + IV_B;
      s1_c         <= c_in + IV_C;
      s1_d         <= d_in + IV_D;
      s1_valid     <= in_valid;
      s1_tag       <= hash_count;
      digest       <= canon;
      digest_valid <= s1_valid;
      if (in_valid)
        hash_count <= hash_count + IDX_W'(1);
    end
  end

  // Sticky match latch; a hit wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      match       <= 1'b0;
      match_multi <= 1'b0;
      match_index <= '0;
    end else if (hit) begin
      if (!match || match_clear) begin
        match       <= 1'b1;
        match_multi <= 1'b0;
        match_index <= s1_tag;
      end else begin
        match_multi <= 1'b1;
      end
    end else if (match_clear) begin
      match       <= 1'b0;
      match_multi <= 1'b0;
    end
  end

endmodule

// File: tb/tb_md5_digest_check.sv
// Self-checking bench for md5_digest_check (IDX_W=4 so the counter wrap is reachable).
// Reference model tracks candidates by digest and tag; literal checks pin known MD5 values.
module tb_md5_digest_check;

  localparam int W = 4;
  localparam logic [127:0] ELIT = 128'hd41d8cd98f00b204e9800998ecf8427e;
  localparam logic [127:0] ZLIT = 128'h0123456789abcdeffedcba9876543210;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic         in_valid;
  logic [31:0]  a_in, b_in, c_in, d_in;
  logic [127:0] target_hash;
  logic         match_clear;
  logic [127:0] digest;
  logic         digest_valid;
  logic         match;
  logic         match_multi;
  logic [W-1:0] match_index;
  logic [W-1:0] hash_count;

  int nchk = 0;
  int nerr = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  md5_digest_check #(.IDX_W(W)) dut (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
    .target_hash(target_hash), .match_clear(match_clear),
    .digest(digest), .digest_valid(digest_valid),
    .match(match), .match_multi(match_multi),
    .match_index(match_index), .hash_count(hash_count)
  );

  // Canonical MD5 digest from round-64 words, by plain arithmetic.
  function automatic logic [127:0] md5_of(input logic [31:0] a, b, c, d);
    logic [31:0] w [4];
    logic [127:0] r;
    w[0] = a + 32'h67452301;
    w[1] = b + 32'hefcdab89;
    w[2] = c + 32'h98badcfe;
    w[3] = d + 32'h10325476;
    r = '0;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++)
        r[127 - 32*k - 8*j -: 8] = w[k][8*j +: 8];
    return r;
  endfunction

  // Reference model: candidates in flight, sticky match bookkeeping.
  logic [127:0] m_fl_dig, m_dig;
  bit   m_fl_v, m_dv, m_match, m_multi, m_hit;
  int   m_fl_tag, m_idx, m_count;

  always @(posedge clk) begin
    if (reset) begin
      m_fl_dig = '0; m_fl_v = 0; m_fl_tag = 0;
      m_dig = '0; m_dv = 0; m_match = 0; m_multi = 0;
      m_idx = 0; m_count = 0;
    end else begin
      m_hit = en && m_fl_v && (m_fl_dig == target_hash);
      if (m_hit) begin
        if (!m_match || match_clear) begin
          m_match = 1; m_multi = 0; m_idx = m_fl_tag;
        end else begin
          m_multi = 1;
        end
      end else if (match_clear) begin
        m_match = 0; m_multi = 0;
      end
      if (en) begin
        m_dig = m_fl_dig;
        m_dv = m_fl_v;
        m_fl_dig = md5_of(a_in, b_in, c_in, d_in);
        m_fl_v = in_valid;
        m_fl_tag = m_count;
        if (in_valid) m_count = (m_count + 1) % (1 << W);
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_digest", digest, m_dig);
      chk("cyc_dvalid", 128'(digest_valid), 128'(m_dv));
      chk("cyc_match", 128'(match), 128'(m_match));
      chk("cyc_multi", 128'(match_multi), 128'(m_multi));
      chk("cyc_index", 128'(match_index), 128'(m_idx));
      chk("cyc_count", 128'(hash_count), 128'(m_count));
    end
  end

  task automatic cyc(input bit e, input bit v, input bit clr,
                     input logic [31:0] a, b, c, d);
    en = e; in_valid = v; match_clear = clr;
    a_in = a; b_in = b; c_in = c; d_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic bub();
    cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic zero_c();
    cyc(1, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic empty_c();
    cyc(1, 1, 0, 32'h7246fad3, 32'h14e45506, 32'hff4ea3eb, 32'h6e10a476);
  endtask

  task automatic do_reset();
    reset = 1;
    bub();
    reset = 0;
  endtask

  initial begin
    reset = 1; en = 0; in_valid = 0; match_clear = 0;
    a_in = 0; b_in = 0; c_in = 0; d_in = 0;
    target_hash = ELIT;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_en = 1;
    chk("rst_digest", digest, 128'h0);
    chk("rst_match", 128'(match), 128'h0);
    chk("rst_count", 128'(hash_count), 128'h0);
    reset = 0;

    for (int i = 0; i < 5; i++) bub();
    chk("idle_dvalid", 128'(digest_valid), 128'h0);
    chk("idle_count", 128'(hash_count), 128'h0);

    // Empty-string vector as 4th valid candidate.
    zero_c(); zero_c(); zero_c();
    chk("zero_digest", digest, ZLIT);
    empty_c();
    bub();
    chk("empty_digest", digest, ELIT);
    chk("empty_dvalid", 128'(digest_valid), 128'h1);
    chk("empty_match", 128'(match), 128'h1);
    chk("empty_index", 128'(match_index), 128'h3);
    chk("empty_count", 128'(hash_count), 128'h4);

    // Clear, then all-zero candidate against target 0.
    cyc(1, 0, 1, 0, 0, 0, 0);
    chk("clear_match", 128'(match), 128'h0);
    target_hash = '0;
    zero_c();
    bub();
    chk("zt_digest", digest, ZLIT);
    chk("zt_match", 128'(match), 128'h0);

    // Stall of three cycles between acceptance and output.
    empty_c();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("stall_dvalid", 128'(digest_valid), 128'h0);
    end
    bub();
    chk("stall_digest", digest, ELIT);
    chk("stall_dvalid2", 128'(digest_valid), 128'h1);

    // Reset with a candidate in flight.
    target_hash = ELIT;
    empty_c();
    do_reset();
    bub();
    chk("mrst_dvalid", 128'(digest_valid), 128'h0);
    chk("mrst_match", 128'(match), 128'h0);
    chk("mrst_count", 128'(hash_count), 128'h0);

    // Matches at 7 and 9, then clear coinciding with a hit at 12.
    for (int i = 0; i < 12; i++) begin
      if (i == 7 || i == 9) empty_c();
      else zero_c();
    end
    bub(); bub();
    chk("multi_index", 128'(match_index), 128'h7);
    chk("multi_flag", 128'(match_multi), 128'h1);
    chk("multi_count", 128'(hash_count), 128'd12);
    empty_c();
    cyc(1, 0, 1, 0, 0, 0, 0);
    chk("clrhit_match", 128'(match), 128'h1);
    chk("clrhit_index", 128'(match_index), 128'd12);
    chk("clrhit_multi", 128'(match_multi), 128'h0);

    // Counter wrap: 17th candidate carries tag 0.
    do_reset();
    for (int i = 0; i < 16; i++) zero_c();
    empty_c();
    bub();
    chk("wrap_count", 128'(hash_count), 128'h1);
    chk("wrap_match", 128'(match), 128'h1);
    chk("wrap_index", 128'(match_index), 128'h0);

    // Clear while stalled.
    cyc(0, 0, 1, 0, 0, 0, 0);
    chk("stclr_match", 128'(match), 128'h0);
    chk("stclr_index", 128'(match_index), 128'h0);
    bub();

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
